// File: rtl/wm_feeder_pkg.sv
// Shared constants for the weight-matrix feeder: lane geometry, state encodings, base address.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package wm_feeder_pkg;

  localparam int WF_LANES = 4;
  localparam int WF_DW    = 32;

  // BRAM_WM128 base address; every read address is offset by it.
  localparam logic [15:0] SADDR_WM128 = 16'd0;

  // One-hot FSM encodings.
  localparam logic [4:0] ST_IDLE   = 5'b00001;
  localparam logic [4:0] ST_COM    = 5'b00010;
  localparam logic [4:0] ST_READ   = 5'b00100;
  localparam logic [4:0] ST_DRAIN  = 5'b01000;
  localparam logic [4:0] ST_FINISH = 5'b10000;

  // Last DRAIN count value; DRAIN covers counts 0..4, long enough for lane 3 to empty.
  localparam logic [2:0] DRAIN_LAST = 3'd4;

  // Words per packed row: K = ((P-1)>>2)+1. Only meaningful for P > 0.
  function automatic logic [15:0] words_per_row(input logic [15:0] p);
    return ((p - 16'd1) >> 2) + 16'd1;
  endfunction

  // Valid-lane mask for the last tile: lanes below P-4*(K-1) carry real weights.
  function automatic logic [WF_LANES-1:0] last_tile_mask(input logic [15:0] p);
    logic [2:0] rem;
    last_tile_mask = '0;
    rem = (p[1:0] == 2'b00) ? 3'd4 : {1'b0, p[1:0]};
    for (int j = 0; j < WF_LANES; j++) begin
      last_tile_mask[j] = (3'(j) < rem);
    end
  endfunction

endpackage

// File: rtl/wm_feeder_skew.sv
// Per-lane skew delay: DEPTH-stage shift register carrying {valid, data}.
// Latency: DEPTH cycles from input to output.
// Backpressure: none; shifts every cycle.
module wm_skew_line #(
  parameter int DW    = 32,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  output logic [DW-1:0] o_dat
);

  logic [DW:0] r_sr [DEPTH];

  // Shift {valid, data} one stage per cycle; reset clears every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= {i_vld, i_dat};
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign {o_vld, o_dat} = r_sr[DEPTH-1];

endmodule

// File: rtl/wm_feeder.sv
// Reads reshaped weight words tile-major from BRAM_WM128 and feeds them diagonally skewed to the array.
// Latency: read in cycle t appears on lane j in cycle t+2+j; finish flag 7 cycles after the last read.
// Backpressure: none; the consumer must take every valid lane.
module wm_feeder
  import wm_feeder_pkg::*;
#(
  parameter int DW    = WF_DW,
  parameter int LANES = WF_LANES,
  parameter int AW    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           P,
  input  logic [15:0]           N,
  input  logic                  feed_start,
  output logic                  feed_finish,
  output logic [AW-1:0]         BRAM_WM128_raddr,
  output logic                  BRAM_WM128_rden,
  input  logic [LANES*DW-1:0]   BRAM_WM128_rddata,
  output logic [LANES*DW-1:0]   w_data,
  output logic [LANES-1:0]      w_valid,
  output logic                  w_tile_first
);

  logic [4:0]       r_state;
  logic [15:0]      r_k_num;
  logic [15:0]      r_n_num;
  logic [15:0]      r_k_cnt;
  logic [15:0]      r_n_cnt;
  logic [15:0]      r_addr;
  logic [2:0]       r_drain;
  logic [LANES-1:0] r_mask;
  logic             r_finish;
  logic             r_rd_vld;
  logic [LANES-1:0] r_rd_mask;
  logic             r_rd_first;
  logic             r_tile_first;

  logic w_reading;
  logic w_last_row;
  logic w_last_tile;

  assign w_reading   = (r_state == ST_READ);
  assign w_last_row  = (r_n_cnt == r_n_num - 16'd1);
  assign w_last_tile = (r_k_cnt == r_k_num - 16'd1);

  assign BRAM_WM128_rden  = w_reading;
  assign BRAM_WM128_raddr = AW'(r_addr + SADDR_WM128);
  assign feed_finish      = r_finish;
  assign w_tile_first     = r_tile_first;

  // Control FSM plus tile/row counters; address steps by K down a tile, then restarts at k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_k_num <= '0;
      r_n_num <= '0;
      r_k_cnt <= '0;
      r_n_cnt <= '0;
      r_addr  <= '0;
      r_drain <= '0;
      r_mask  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (feed_start) r_state <= ST_COM;
        end
        ST_COM: begin
          r_k_num <= words_per_row(P);
          r_n_num <= N;
          r_mask  <= last_tile_mask(P);
          r_k_cnt <= '0;
          r_n_cnt <= '0;
          r_addr  <= '0;
          r_state <= ((P == 16'd0) || (N == 16'd0)) ? ST_FINISH : ST_READ;
        end
        ST_READ: begin
          if (w_last_row) begin
            r_n_cnt <= '0;
            if (w_last_tile) begin
              r_drain <= '0;
              r_state <= ST_DRAIN;
            end else begin
              r_k_cnt <= r_k_cnt + 16'd1;
              r_addr  <= r_k_cnt + 16'd1;
            end
          end else begin
            r_n_cnt <= r_n_cnt + 16'd1;
            r_addr  <= r_addr + r_k_num;
          end
        end
        ST_DRAIN: begin
          if (r_drain == DRAIN_LAST) r_state <= ST_FINISH;
          else                       r_drain <= r_drain + 3'd1;
        end
        ST_FINISH: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky finish: cleared when a job is accepted, set on leaving FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       r_finish <= 1'b0;
    else if ((r_state == ST_IDLE) && feed_start)      r_finish <= 1'b0;
    else if (r_state == ST_FINISH)                    r_finish <= 1'b1;
  end

  // Align per-read side info with the BRAM data that returns one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld     <= 1'b0;
      r_rd_mask    <= '0;
      r_rd_first   <= 1'b0;
      r_tile_first <= 1'b0;
    end else begin
      r_rd_vld     <= w_reading;
      r_rd_mask    <= w_last_tile ? r_mask : '1;
      r_rd_first   <= (r_n_cnt == 16'd0);
      r_tile_first <= r_rd_vld & r_rd_first;
    end
  end

  // Lane j is delayed j+1 register stages, giving the diagonal skew.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    wm_skew_line #(
      .DW    (DW),
      .DEPTH (j + 1)
    ) u_skew (
      .clk   (clk),
      .rst_n (rst_n),
      .i_vld (r_rd_vld & r_rd_mask[j]),
      .i_dat (BRAM_WM128_rddata[DW*j +: DW]),
      .o_vld (w_valid[j]),
      .o_dat (w_data[DW*j +: DW])
    );
  end

endmodule
